// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard scheduler
package hazard_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // M is younger than W, so its result must win when both target the same register.
  function automatic fwd_sel_e fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m,
                                        input logic       we_m,
                                        input logic [4:0] rd_w,
                                        input logic       we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return FWD_M;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      cnt <= '0;
    else if (i_clr)
      cnt <= '0;
    else if (i_inc && (cnt != {W{1'b1}}))
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

  assign o_cnt = cnt;

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - stall/flush/redirect/forwarding control for the five-stage core
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_instr_valid_F,
  input  logic             i_prediction_F,
  input  logic [4:0]       i_rs1_D,
  input  logic [4:0]       i_rs2_D,
  input  logic [4:0]       i_rs1_E,
  input  logic [4:0]       i_rs2_E,
  input  logic [4:0]       i_rd_E,
  input  logic             i_memread_E,
  input  logic [4:0]       i_rd_M,
  input  logic [4:0]       i_rd_W,
  input  logic             i_regwrite_M,
  input  logic             i_regwrite_W,
  input  logic             i_branch_E,
  input  logic             i_jump_E,
  input  logic             i_mispredict_E,
  input  logic             i_cnt_clr,
  output logic             o_stall_F,
  output logic             o_stall_D,
  output logic             o_flush_D,
  output logic             o_flush_E,
  output logic             o_redirect,
  output logic             o_valid_E,
  output logic             o_pred_E,
  output logic [1:0]       o_fwd_A_E,
  output logic [1:0]       o_fwd_B_E,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  logic       v_D, v_E, pred_D, pred_E;
  logic       redirect, lu;
  logic       stall_f, stall_d, flush_d, flush_e;
  fsm_state_e state, state_nxt;

  assign redirect = i_mispredict_E & v_E;
  assign lu = i_memread_E & v_E & v_D & (i_rd_E != 5'd0) &
              ((i_rd_E == i_rs1_D) | (i_rd_E == i_rs2_D));

  // A redirect makes the D instruction wrong-path, so it overrides the load-use stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      v_D    <= 1'b0;
      v_E    <= 1'b0;
      pred_D <= 1'b0;
      pred_E <= 1'b0;
    end else begin
      if (flush_d) begin
        v_D    <= 1'b0;
        pred_D <= 1'b0;
      end else if (!stall_d) begin
        v_D    <= i_instr_valid_F;
        pred_D <= i_prediction_F;
      end
      if (flush_e) begin
        v_E    <= 1'b0;
        pred_E <= 1'b0;
      end else begin
        v_E    <= v_D;
        pred_E <= pred_D;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      state_nxt = redirect ? REDIRECT : (lu ? LU_STALL : RUN);
      LU_STALL: state_nxt = redirect ? REDIRECT : RUN;
      REDIRECT: state_nxt = lu ? LU_STALL : RUN;
      default:  state_nxt = RUN;
    endcase
  end

  assign o_stall_F  = stall_f;
  assign o_stall_D  = stall_d;
  assign o_flush_D  = flush_d;
  assign o_flush_E  = flush_e;
  assign o_redirect = redirect;
  assign o_valid_E  = v_E;
  assign o_pred_E   = pred_E;
  assign o_state    = state;
  assign o_fwd_A_E  = fwd_pick(i_rs1_E, i_rd_M, i_regwrite_M, i_rd_W, i_regwrite_W);
  assign o_fwd_B_E  = fwd_pick(i_rs2_E, i_rd_M, i_regwrite_M, i_rd_W, i_regwrite_W);

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (v_E & i_branch_E),
    .o_cnt (o_branch_cnt)
  );

  // Jump redirects are real but are not branch mispredictions.
  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (redirect & i_branch_E & ~i_jump_E),
    .o_cnt (o_mispred_cnt)
  );

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - scoreboard bench for hazard_sched
module tb_hazard_sched;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_instr_valid_F, i_prediction_F;
  logic [4:0] i_rs1_D, i_rs2_D, i_rs1_E, i_rs2_E, i_rd_E, i_rd_M, i_rd_W;
  logic       i_memread_E, i_regwrite_M, i_regwrite_W;
  logic       i_branch_E, i_jump_E, i_mispredict_E, i_cnt_clr;
  logic       o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_redirect;
  logic       o_valid_E, o_pred_E;
  logic [1:0] o_fwd_A_E, o_fwd_B_E, o_state;
  logic [3:0] o_branch_cnt, o_mispred_cnt;

  always #5 clk = ~clk;

  hazard_sched #(.CNT_W(4)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_instr_valid_F(i_instr_valid_F), .i_prediction_F(i_prediction_F),
    .i_rs1_D(i_rs1_D), .i_rs2_D(i_rs2_D),
    .i_rs1_E(i_rs1_E), .i_rs2_E(i_rs2_E), .i_rd_E(i_rd_E),
    .i_memread_E(i_memread_E), .i_rd_M(i_rd_M), .i_rd_W(i_rd_W),
    .i_regwrite_M(i_regwrite_M), .i_regwrite_W(i_regwrite_W),
    .i_branch_E(i_branch_E), .i_jump_E(i_jump_E),
    .i_mispredict_E(i_mispredict_E), .i_cnt_clr(i_cnt_clr),
    .o_stall_F(o_stall_F), .o_stall_D(o_stall_D),
    .o_flush_D(o_flush_D), .o_flush_E(o_flush_E), .o_redirect(o_redirect),
    .o_valid_E(o_valid_E), .o_pred_E(o_pred_E),
    .o_fwd_A_E(o_fwd_A_E), .o_fwd_B_E(o_fwd_B_E), .o_state(o_state),
    .o_branch_cnt(o_branch_cnt), .o_mispred_cnt(o_mispred_cnt)
  );

  typedef struct {
    string      name;
    int         kind;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  logic [12:0] act;
  logic [12:0] ctrl_vec;

  assign ctrl_vec = {o_stall_F, o_stall_D, o_flush_D, o_flush_E, o_redirect,
                     o_valid_E, o_pred_E, o_fwd_A_E, o_fwd_B_E, o_state};

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        1:       act = {9'd0, o_branch_cnt};
        2:       act = {9'd0, o_mispred_cnt};
        default: act = ctrl_vec;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: actual=%b required=%b", e.name, act, e.exp);
      end
    end
  end

  // Control vector order: stall_F stall_D flush_D flush_E redirect valid_E pred_E fwd_A fwd_B state
  task automatic exp_c(input string n, input logic sf, input logic sd, input logic fd,
                       input logic fe, input logic rd, input logic ve, input logic pe,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] st);
    exp_t x;
    x.name = n;
    x.kind = 0;
    x.exp  = {sf, sd, fd, fe, rd, ve, pe, fa, fb, st};
    sb.push_back(x);
  endtask

  task automatic exp_n(input string n, input int k, input logic [3:0] v);
    exp_t x;
    x.name = n;
    x.kind = k;
    x.exp  = {9'd0, v};
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b0;
    {i_instr_valid_F, i_prediction_F, i_memread_E, i_regwrite_M, i_regwrite_W} = '0;
    {i_branch_E, i_jump_E, i_mispredict_E, i_cnt_clr} = '0;
    {i_rs1_D, i_rs2_D, i_rs1_E, i_rs2_E, i_rd_E, i_rd_M, i_rd_W} = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_c("reset_ctrl", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);
    exp_n("reset_bcnt", 1, 4'd0);
    exp_n("reset_mcnt", 2, 4'd0);

    // fill the pipe
    step(); i_rst = 1'b1; i_instr_valid_F = 1'b1; i_prediction_F = 1'b1;
    exp_c("fill0", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);
    step(); i_prediction_F = 1'b0;
    exp_c("fill1", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);
    step();
    exp_c("fill2_vE", 0,0,0,0,0,1,1, 2'b00, 2'b00, 2'd0);

    // load-use on x5
    step(); i_memread_E = 1'b1; i_rd_E = 5'd5; i_rs1_D = 5'd5;
    exp_c("lu_stall", 1,1,0,1,0,1,0, 2'b00, 2'b00, 2'd0);
    step(); i_memread_E = 1'b0;
    exp_c("lu_state", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd1);
    step(); i_memread_E = 1'b1; i_rd_E = 5'd0; i_rs1_D = 5'd0;
    exp_c("lu_x0", 0,0,0,0,0,1,0, 2'b00, 2'b00, 2'd0);

    // branch mispredict, then raw mispredict ignored while E is empty
    step(); i_memread_E = 1'b0; i_mispredict_E = 1'b1; i_branch_E = 1'b1;
    exp_c("redirect", 0,0,1,1,1,1,0, 2'b00, 2'b00, 2'd0);
    exp_n("bcnt_pre", 1, 4'd0);
    step();
    exp_c("shadow1", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd2);
    exp_n("bcnt_post", 1, 4'd1);
    exp_n("mcnt_post", 2, 4'd1);
    step();
    exp_c("shadow2", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);
    step(); i_mispredict_E = 1'b0; i_branch_E = 1'b0;
    exp_c("recovered", 0,0,0,0,0,1,0, 2'b00, 2'b00, 2'd0);

    // jump mispredict colliding with load-use
    step(); i_mispredict_E = 1'b1; i_jump_E = 1'b1; i_memread_E = 1'b1;
    i_rd_E = 5'd5; i_rs1_D = 5'd5;
    exp_c("redir_beats_lu", 0,0,1,1,1,1,0, 2'b00, 2'b00, 2'd0);
    step(); {i_mispredict_E, i_jump_E, i_memread_E} = '0; i_rd_E = 5'd0; i_rs1_D = 5'd0;
    exp_c("jump_after", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd2);
    exp_n("jump_not_counted", 2, 4'd1);
    step();
    exp_c("jump_after2", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);

    // forwarding
    step(); i_rs1_E = 5'd7; i_rs2_E = 5'd7; i_rd_M = 5'd7; i_rd_W = 5'd7;
    i_regwrite_M = 1'b1; i_regwrite_W = 1'b1;
    exp_c("fwd_m_wins", 0,0,0,0,0,1,0, 2'b10, 2'b10, 2'd0);
    step(); i_regwrite_M = 1'b0;
    exp_c("fwd_w", 0,0,0,0,0,1,0, 2'b01, 2'b01, 2'd0);
    step(); i_regwrite_M = 1'b1; i_rs1_E = 5'd0; i_rd_M = 5'd0; i_rd_W = 5'd0;
    exp_c("fwd_x0", 0,0,0,0,0,1,0, 2'b00, 2'b00, 2'd0);
    step(); i_rd_W = 5'd7;
    exp_c("fwd_m_rd0", 0,0,0,0,0,1,0, 2'b00, 2'b01, 2'd0);
    step(); {i_regwrite_M, i_regwrite_W} = '0; {i_rs1_E, i_rs2_E, i_rd_M, i_rd_W} = '0;

    // saturation at 15 with CNT_W = 4
    i_branch_E = 1'b1;
    for (int k = 0; k < 20; k++) begin
      exp_n($sformatf("sat%0d", k), 1, (k + 1 > 15) ? 4'd15 : 4'(k + 1));
      step();
    end
    i_cnt_clr = 1'b1;
    exp_n("clr_cycle", 1, 4'd15);
    step(); i_branch_E = 1'b0; i_cnt_clr = 1'b0;
    exp_n("clr_bcnt", 1, 4'd0);
    exp_n("clr_mcnt", 2, 4'd0);

    // asynchronous reset mid-operation
    step(); i_branch_E = 1'b1; i_rs1_E = 5'd7; i_rd_M = 5'd7; i_regwrite_M = 1'b1;
    exp_c("pre_rst", 0,0,0,0,0,1,0, 2'b10, 2'b00, 2'd0);
    step(); i_mispredict_E = 1'b1; i_rst = 1'b0;
    exp_c("async_rst", 0,0,0,0,0,0,0, 2'b10, 2'b00, 2'd0);
    exp_n("async_rst_bcnt", 1, 4'd0);
    step(); i_rst = 1'b1; {i_mispredict_E, i_branch_E, i_regwrite_M} = '0;
    exp_c("post_rst", 0,0,0,0,0,0,0, 2'b00, 2'b00, 2'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d required=0 pending", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
